me_full_search: RTL and testbench
=================================

// Module: me_full_search
// PURPOSE
//  Parametrised full-search integer motion-estimation engine for the inter-prediction path.
//  - Scans every candidate position of a MACRO_DIM x MACRO_DIM block inside a SEARCH_DIM x SEARCH_DIM window.
//  - Computes one candidate row SAD per cycle.
//  - Returns the minimum SAD and its position.
//  - Adds a candidate STEP, optional early termination, a start/ready and valid/ack handshake, and a cycle counter.
//  - Pixels come from external async-read RAMs addressed by this block.
// PARAMETERS
//  MACRO_DIM   16  block edge in pixels
//  SEARCH_DIM  48  window edge in pixels; must be >= MACRO_DIM
//  STEP        1   candidate stride in x and y; 1 = exhaustive search
//  Derived:
//   MAXP  = SEARCH_DIM-MACRO_DIM
//   POS_W = $clog2(MAXP+1)
//   SAD_W = $clog2(MACRO_DIM*MACRO_DIM*255+1)
//   ROW_W = $clog2(MACRO_DIM)
// PORTS
//  clk            in   1           clock
//  rst            in   1           async reset, active-high
//  start          in   1           begin search; sampled only while ready=1
//  early_term_en  in   1           enable early candidate abort; latched at start
//  ready          out  1           1 in IDLE
//  cur_row        out  ROW_W       current-block row address
//  srch_x         out  POS_W       window column of candidate pixel 0
//  srch_y         out  $clog2(SEARCH_DIM)  window row address
//  pixel_cpr_in   in   8 x MACRO_DIM  current-block row cur_row; valid same cycle
//  pixel_spr_in   in   8 x MACRO_DIM  window pixels (srch_y, srch_x+i); valid same cycle
//  valid          out  1           result available; held until ack
//  ack            in   1           consumer accepts the result
//  min_sad        out  SAD_W       minimum SAD
//  mv_x, mv_y     out  POS_W       best candidate top-left position, unsigned, 0..MAXP
//  cyc_cnt        out  32          SCAN cycles spent on the last search
// BEHAVIOUR
//  Reset: FSM=IDLE; ready=1; valid=0; all address, result and cyc_cnt outputs =0.
//  FSM IDLE:
//   - start=1 -> SCAN.
//   - On entry: latch early_term_en; cand=(0,0); row=0; acc=0; best=all-ones; cyc_cnt=0.
//  FSM SCAN, each cycle:
//   - Drive cur_row=row, srch_x=cand_x, srch_y=cand_y+row.
//   - rsad = sum over i of |cpr[i]-spr[i]|, unsigned, no saturation.
//   - sum = acc + rsad; cyc_cnt += 1.
//   - Row done, row==MACRO_DIM-1: if sum<best, best=sum and mv=cand. Then acc=0, row=0, advance.
//   - Early abort: en and row<MACRO_DIM-1 and sum>=best -> acc=0, row=0, advance; mv/best unchanged.
//   - Otherwise: acc=sum, row+=1.
//   - Advance:
//     - If cand_x+STEP <= MAXP: cand_x += STEP.
//     - Else cand_x=0 and cand_y += STEP.
//     - If cand_y+STEP > MAXP as well: last candidate done -> DONE.
//  FSM DONE:
//   - valid=1; min_sad=best; mv held.
//   - ack=1 -> IDLE; valid falls the next cycle.
//  Result outputs hold until the next start.
//  Tie rule: strict less-than, so the first candidate in raster order wins.
//  Abort correctness: every abort has partial >= best, so aborts never change the result.
//  Cycle count: exhaustive search takes exactly ((MAXP/STEP)+1)^2 * MACRO_DIM SCAN cycles.
//  start outside IDLE is ignored. ack outside DONE is ignored.
//  start and ack in the same cycle as the DONE entry: ack is not seen until valid=1.
//  MAXP=0: a single candidate; the search takes MACRO_DIM cycles.
//  rst mid-SCAN or DONE: immediate IDLE and reset values; the partial search is discarded.
// TESTING (defaults unless stated)
//  1 Exhaustive match:
//    - Stimulus: cur block random bytes 1..255; window all 0x00 except a copy of the block at (10,7); en=0.
//    - Required: min_sad=0, mv=(10,7), cyc_cnt=17424.
//  2 Uniform tie:
//    - Stimulus: cur all 0x10; window all 0x10.
//    - Required: min_sad=0, mv=(0,0).
//  3 Max SAD:
//    - Stimulus: cur all 0xFF; window all 0x00.
//    - Required: min_sad=65280 (0xFF00), mv=(0,0); no overflow.
//  4 Early termination:
//    - Stimulus: scenario 1 stimulus with en=1.
//    - Required: same min_sad and mv; cyc_cnt < 17424.
//  5 Handshake and STEP:
//    - STEP=2: 17x17 candidates, cyc_cnt=4624.
//    - Delay ack by 5 cycles: valid and min_sad stable throughout.
//    - start during SCAN: ignored.
//  6 Reset mid-scan:
//    - Assert rst at SCAN cycle 500: ready=1, valid=0, outputs 0 immediately.
//    - Restart with scenario 1 stimulus: identical result.

Source files
------------

// File: rtl/me_full_search.sv
// Full-search integer motion estimation. Walks every candidate position of a
// MACRO_DIM x MACRO_DIM block inside a SEARCH_DIM x SEARCH_DIM window, one
// candidate row SAD per cycle, and reports the minimum SAD and its position.
module me_full_search #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int STEP       = 1,
    localparam int MAXP  = SEARCH_DIM - MACRO_DIM,
    localparam int POS_W = (MAXP > 0) ? $clog2(MAXP + 1) : 1,
    localparam int SAD_W = $clog2(MACRO_DIM * MACRO_DIM * 255 + 1),
    localparam int ROW_W = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1,
    localparam int SY_W  = (SEARCH_DIM > 1) ? $clog2(SEARCH_DIM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         early_term_en,
    output logic                         ready,
    output logic [ROW_W-1:0]             cur_row,
    output logic [POS_W-1:0]             srch_x,
    output logic [SY_W-1:0]              srch_y,
    input  logic [MACRO_DIM-1:0][7:0]    pixel_cpr_in,
    input  logic [MACRO_DIM-1:0][7:0]    pixel_spr_in,
    output logic                         valid,
    input  logic                         ack,
    output logic [SAD_W-1:0]             min_sad,
    output logic [POS_W-1:0]             mv_x,
    output logic [POS_W-1:0]             mv_y,
    output logic [31:0]                  cyc_cnt
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state, state_nxt;
    logic                 et_en;
    logic [POS_W-1:0]     cand_x, cand_y, best_x, best_y;
    logic [ROW_W-1:0]     row;
    logic [SAD_W-1:0]     acc, best, rsad, sum;
    logic [MACRO_DIM-1:0][7:0] ad;
    logic                 row_last, abort, cand_end, x_wrap, y_last, last, better;

    // Per-lane absolute difference between block and window pixel
    for (genvar i = 0; i < MACRO_DIM; i++) begin : g_lane
        assign ad[i] = (pixel_cpr_in[i] >= pixel_spr_in[i]) ? pixel_cpr_in[i] - pixel_spr_in[i]
                                                           : pixel_spr_in[i] - pixel_cpr_in[i];
    end

    // Row SAD reduction and candidate bookkeeping decisions
    always_comb begin
        rsad = '0;
        for (int i = 0; i < MACRO_DIM; i++) rsad = rsad + SAD_W'(ad[i]);
        sum      = acc + rsad;
        row_last = (row == ROW_W'(MACRO_DIM - 1));
        // a partial sum already at or above best can never win (strict less-than)
        abort    = et_en && !row_last && (sum >= best);
        better   = row_last && (sum < best);
        cand_end = row_last || abort;
        x_wrap   = (int'(cand_x) + STEP > MAXP);
        y_last   = (int'(cand_y) + STEP > MAXP);
        last     = cand_end && x_wrap && y_last;
    end

    assign ready   = (state == IDLE);
    assign valid   = (state == DONE);
    assign cur_row = row;
    assign srch_x  = cand_x;
    assign srch_y  = SY_W'(cand_y) + SY_W'(row);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: start only seen in IDLE, ack only seen in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = DONE;
            DONE:    if (ack)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan datapath: accumulate rows, track best, step candidates, publish result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            et_en   <= 1'b0;
            cand_x  <= '0;
            cand_y  <= '0;
            row     <= '0;
            acc     <= '0;
            best    <= '1;
            best_x  <= '0;
            best_y  <= '0;
            cyc_cnt <= '0;
            min_sad <= '0;
            mv_x    <= '0;
            mv_y    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    et_en   <= early_term_en;
                    cand_x  <= '0;
                    cand_y  <= '0;
                    row     <= '0;
                    acc     <= '0;
                    best    <= '1;
                    cyc_cnt <= '0;
                end
                SCAN: begin
                    cyc_cnt <= cyc_cnt + 32'd1;
                    if (better) begin
                        best   <= sum;
                        best_x <= cand_x;
                        best_y <= cand_y;
                    end
                    if (cand_end) begin
                        acc <= '0;
                        row <= '0;
                        if (!x_wrap) begin
                            cand_x <= cand_x + POS_W'(STEP);
                        end else begin
                            cand_x <= '0;
                            // park at (0,0) after the final candidate so addresses idle at zero
                            cand_y <= y_last ? '0 : cand_y + POS_W'(STEP);
                        end
                    end else begin
                        acc <= sum;
                        row <= row + ROW_W'(1);
                    end
                    if (last) begin
                        min_sad <= better ? sum    : best;
                        mv_x    <= better ? cand_x : best_x;
                        mv_y    <= better ? cand_y : best_y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_me_full_search.sv
// Scoreboard bench: stimulus pushes the expected result, per-DUT monitors pop
// and compare when valid rises, and check min_sad stays put while valid holds.
module tb_me_full_search;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] cur [16][16];
    logic [7:0] win [48][48];

    // u0: STEP=1, u1: STEP=2
    logic start0 = 0, en0 = 0, ack0 = 0, ready0, valid0;
    logic start1 = 0, en1 = 0, ack1 = 0, ready1, valid1;
    logic [3:0]  row0, row1;
    logic [5:0]  sx0, sy0, sx1, sy1, mx0, my0, mx1, my1;
    logic [15:0][7:0] cpr0, spr0, cpr1, spr1;
    logic [15:0] sad0, sad1;
    logic [31:0] cyc0, cyc1;

    me_full_search #(.MACRO_DIM(16), .SEARCH_DIM(48), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .early_term_en(en0), .ready(ready0),
        .cur_row(row0), .srch_x(sx0), .srch_y(sy0), .pixel_cpr_in(cpr0), .pixel_spr_in(spr0),
        .valid(valid0), .ack(ack0), .min_sad(sad0), .mv_x(mx0), .mv_y(my0), .cyc_cnt(cyc0));

    me_full_search #(.MACRO_DIM(16), .SEARCH_DIM(48), .STEP(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .early_term_en(en1), .ready(ready1),
        .cur_row(row1), .srch_x(sx1), .srch_y(sy1), .pixel_cpr_in(cpr1), .pixel_spr_in(spr1),
        .valid(valid1), .ack(ack1), .min_sad(sad1), .mv_x(mx1), .mv_y(my1), .cyc_cnt(cyc1));

    // Async-read pixel memories
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cpr0[i] = cur[row0][i];
            spr0[i] = win[sy0][int'(sx0) + i];
            cpr1[i] = cur[row1][i];
            spr1[i] = win[sy1][int'(sx1) + i];
        end
    end

    typedef struct {int sad; int mx; int my; int cyc; int cmode;} exp_t; // cmode 0: exact cyc, 1: cyc below
    exp_t q0[$], q1[$];
    exp_t h0, h1;
    logic v0q = 0, v1q = 0;
    int n_cmp = 0, n_bad = 0;

    function automatic exp_t mk(input int sad, input int mx, input int my, input int cyc, input int cmode);
        exp_t e;
        e.sad = sad; e.mx = mx; e.my = my; e.cyc = cyc; e.cmode = cmode;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input int sad, input int mx, input int my, input int cyc, input exp_t e);
        chk({nm, "_min_sad"}, sad, e.sad);
        chk({nm, "_mv_x"}, mx, e.mx);
        chk({nm, "_mv_y"}, my, e.my);
        if (e.cmode == 0) chk({nm, "_cyc_cnt"}, cyc, e.cyc);
        else              chk({nm, "_cyc_below"}, int'(cyc < e.cyc), 1);
    endtask

    // Monitor u0
    always @(negedge clk) begin
        if (valid0 && !v0q) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u0_unexpected: got result sad %0d expected none", sad0);
            end else begin
                h0 = q0.pop_front();
                chk_res("u0", int'(sad0), int'(mx0), int'(my0), int'(cyc0), h0);
            end
        end else if (valid0) begin
            chk("u0_hold_sad", int'(sad0), h0.sad);
        end
        v0q <= valid0;
    end

    // Monitor u1
    always @(negedge clk) begin
        if (valid1 && !v1q) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u1_unexpected: got result sad %0d expected none", sad1);
            end else begin
                h1 = q1.pop_front();
                chk_res("u1", int'(sad1), int'(mx1), int'(my1), int'(cyc1), h1);
            end
        end else if (valid1) begin
            chk("u1_hold_sad", int'(sad1), h1.sad);
        end
        v1q <= valid1;
    end

    // Search on u0; poke issues start+ack (with flipped enable) mid-scan, which must be ignored
    task automatic run0(input logic en, input exp_t e, input int ack_dly, input bit poke);
        int t;
        q0.push_back(e);
        @(negedge clk); start0 = 1; en0 = en;
        @(negedge clk); start0 = 0; en0 = 0;
        if (poke) begin
            repeat (100) @(negedge clk);
            start0 = 1; ack0 = 1; en0 = ~en;
            @(negedge clk); start0 = 0; ack0 = 0; en0 = 0;
        end
        t = 0;
        while (!valid0 && t < 20000) begin @(negedge clk); t++; end
        if (!valid0) begin
            n_cmp++; n_bad++;
            $display("FAIL u0_timeout: got no valid after %0d cycles expected valid", t);
        end else begin
            repeat (ack_dly) @(negedge clk);
            ack0 = 1; @(negedge clk); ack0 = 0; @(negedge clk);
        end
    endtask

    task automatic run1(input logic en, input exp_t e, input int ack_dly);
        int t;
        q1.push_back(e);
        @(negedge clk); start1 = 1; en1 = en;
        @(negedge clk); start1 = 0; en1 = 0;
        t = 0;
        while (!valid1 && t < 20000) begin @(negedge clk); t++; end
        if (!valid1) begin
            n_cmp++; n_bad++;
            $display("FAIL u1_timeout: got no valid after %0d cycles expected valid", t);
        end else begin
            repeat (ack_dly) @(negedge clk);
            ack1 = 1; @(negedge clk); ack1 = 0; @(negedge clk);
        end
    endtask

    task automatic fill(input logic [7:0] cv, input logic [7:0] wv);
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur[r][c] = cv;
        for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) win[r][c] = wv;
    endtask

    // Random nonzero block, zero window with an exact copy at x=10, y=7
    task automatic load_match();
        fill(8'h00, 8'h00);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                cur[r][c] = 8'($urandom_range(1, 255));
                win[7 + r][10 + c] = cur[r][c];
            end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ready0"}, int'(ready0), 1);
        chk({nm, "_valid0"}, int'(valid0), 0);
        chk({nm, "_sad0"},   int'(sad0), 0);
        chk({nm, "_mvx0"},   int'(mx0), 0);
        chk({nm, "_mvy0"},   int'(my0), 0);
        chk({nm, "_cyc0"},   int'(cyc0), 0);
        chk({nm, "_row0"},   int'(row0), 0);
        chk({nm, "_sx0"},    int'(sx0), 0);
        chk({nm, "_sy0"},    int'(sy0), 0);
        chk({nm, "_ready1"}, int'(ready1), 1);
        chk({nm, "_valid1"}, int'(valid1), 0);
        chk({nm, "_sad1"},   int'(sad1), 0);
        chk({nm, "_cyc1"},   int'(cyc1), 0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        fill(8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 0;
        @(negedge clk);

        // uniform tie with early termination: (0,0) full 16 rows, 1088 one-row aborts
        fill(8'h10, 8'h10);
        run0(1'b1, mk(0, 0, 0, 1104, 0), 1, 1'b0);

        // maximum SAD on the STEP=2 engine: 17x17 candidates x 16 rows
        fill(8'hFF, 8'h00);
        run1(1'b0, mk(65280, 0, 0, 4624, 0), 3);

        // exhaustive match, ack delayed 5 cycles, stray start/ack mid-scan
        load_match();
        run0(1'b0, mk(0, 10, 7, 17424, 0), 5, 1'b1);

        // same stimulus with early termination
        run0(1'b1, mk(0, 10, 7, 17424, 1), 1, 1'b0);

        // reset 500 cycles into a scan
        @(negedge clk); start0 = 1;
        @(negedge clk); start0 = 0;
        repeat (499) @(negedge clk);
        chk("midscan_busy", int'(ready0), 0);
        rst = 1;
        #1;
        chk_idle("midrst");
        @(negedge clk); rst = 0;
        @(negedge clk);

        // restart after reset gives the full result again
        run0(1'b0, mk(0, 10, 7, 17424, 0), 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("q0_pending", q0.size(), 0);
        chk("q1_pending", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
